add_reg: RTL and testbench



---
 rtl/add_pkg.sv | 16 +
 rtl/add_if.sv | 16 +
 rtl/add_ripple.sv | 30 +++
 rtl/add_reg.sv | 82 ++++++++
 tb/tb_add_reg.sv | 134 +++++++++++++
 5 files changed

// File: rtl/add_pkg.sv
// Shared constants and types for the registered adder.
// Define ADD_REG_IN_STAGE_EN to add an input register stage (latency 2).
package add_pkg;

    localparam int ADD_WIDTH_DEFAULT = 4;

    typedef logic [ADD_WIDTH_DEFAULT-1:0] operand_t;
    typedef logic [ADD_WIDTH_DEFAULT:0]   result_t;

`ifdef ADD_REG_IN_STAGE_EN
    localparam int LATENCY = 2;
`else
    localparam int LATENCY = 1;
`endif

endpackage

// File: rtl/add_if.sv
// Operand/result bundle for add_reg; master drives operands, slave returns the sum.
interface add_if
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEFAULT
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   sum;
    logic             out_valid;

    modport master (output a, output b, input sum, input out_valid);
    modport slave  (input a, input b, output sum, output out_valid);

endinterface

// File: rtl/add_ripple.sv
// Combinational WIDTH-bit ripple-carry adder built from per-bit full adders.
module add_ripple
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    // Each bit keeps its carry locally so the chain is not a self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic cin;
        logic co;

        if (i == 0) begin : g_lsb
            assign cin = 1'b0;
        end else begin : g_chain
            assign cin = g_bit[i-1].co;
        end

        assign s[i] = a[i] ^ b[i] ^ cin;
        assign co   = (a[i] & b[i]) | (cin & (a[i] ^ b[i]));
    end

    assign cout = g_bit[WIDTH-1].co;

endmodule

// File: rtl/add_reg.sv
// Registered unsigned adder: sum = a + b (carry in MSB), out_valid after first result.
// Define ADD_REG_IN_STAGE_EN to register the operands first (latency 2).
module add_reg
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH_DEFAULT
) (
    input  logic  clk,
    input  logic  rst_n,
    add_if.slave  bus
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             result_ready;

`ifdef ADD_REG_IN_STAGE_EN
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             stage_vld_q, stage_vld_d;

    always_comb begin
        a_d         = bus.a;
        b_d         = bus.b;
        stage_vld_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            stage_vld_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            stage_vld_q <= stage_vld_d;
        end
    end

    assign op_a         = a_q;
    assign op_b         = b_q;
    assign result_ready = stage_vld_q;
`else
    assign op_a         = bus.a;
    assign op_b         = bus.b;
    assign result_ready = 1'b1;
`endif

    logic [WIDTH-1:0] ripple_s;
    logic             ripple_cout;

    add_ripple #(.WIDTH(WIDTH)) u_ripple (
        .a    (op_a),
        .b    (op_b),
        .s    (ripple_s),
        .cout (ripple_cout)
    );

    logic [WIDTH:0] sum_q, sum_d;
    logic           out_valid_q, out_valid_d;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        sum_d       = {ripple_cout, ripple_s};
        out_valid_d = result_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_add_reg.sv
// Self-checking bench for add_reg: queue-based reference model plus directed literal checks.
module tb_add_reg;
    import add_pkg::*;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    add_if #(.WIDTH(W)) bus ();

    add_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each sampled pair's sum emerges LATENCY edges later.
    int edges = 0;
    int pipe[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges = 0;
            pipe.delete();
        end else begin
            pipe.push_back(int'(bus.a) + int'(bus.b));
            edges++;
            if (pipe.size() > LATENCY) void'(pipe.pop_front());
        end
    end

    always @(negedge clk) begin
        if (edges >= LATENCY) begin
            check("cyc_sum", 32'(bus.sum), pipe[0]);
            check("cyc_valid", 32'(bus.out_valid), 1);
        end else begin
            check("cyc_sum_idle", 32'(bus.sum), 0);
            check("cyc_valid_idle", 32'(bus.out_valid), 0);
        end
    end

    task automatic wait_result();
        repeat (LATENCY) @(posedge clk);
        #1;
    endtask

    task automatic apply(input string name, input int av, input int bv, input int exp);
        bus.a = W'(av);
        bus.b = W'(bv);
        wait_result();
        check(name, 32'(bus.sum), exp);
    endtask

    initial begin
        bus.a = 4'd1;
        bus.b = 4'd5;
        #15;
        check("rst_hold_sum", 32'(bus.sum), 0);
        check("rst_hold_valid", 32'(bus.out_valid), 0);

        rst_n = 1'b1;
        wait_result();
        check("basic_sum", 32'(bus.sum), 6);
        check("basic_valid", 32'(bus.out_valid), 1);
        repeat (2) @(posedge clk);
        #1;
        check("basic_hold", 32'(bus.sum), 6);

        bus.a = 4'd3;
        #10;
        bus.a = 4'd4;
        wait_result();
        check("late_change", 32'(bus.sum), 9);
        #4;
        bus.a = 4'd6;
        #4;
        check("between_edges", 32'(bus.sum), 9);
        wait_result();
        check("after_change", 32'(bus.sum), 11);

        apply("carry_max", 15, 15, 30);
        apply("carry_msb", 15, 1, 16);
        apply("zero", 0, 0, 0);
        apply("mid", 9, 6, 15);

        for (int i = 0; i < 256; i++) begin
            bus.a = W'(i >> 4);
            bus.b = W'(i & 15);
            @(posedge clk);
            #1;
        end
        wait_result();

        bus.a = 4'd7;
        bus.b = 4'd8;
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_rst_sum", 32'(bus.sum), 0);
        check("async_rst_valid", 32'(bus.out_valid), 0);
        #6;
        rst_n = 1'b1;
        wait_result();
        check("rerun_sum", 32'(bus.sum), 15);
        check("rerun_valid", 32'(bus.out_valid), 1);
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
